// File: rtl/cpu_if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package cpu_if_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid, stall holds, load captures,
// otherwise a bubble is inserted while the payload fields hold.
module if_id_reg
    import cpu_if_pkg::*;
#(
    parameter int unsigned           ADDR_W    = ADDR_W_DEF,
    parameter int unsigned           INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0]    NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               stall_i,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc_plus4_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            instr_o    <= NOP_INSTR;
            pc_o       <= '0;
            pc_plus4_o <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o <= load_i;
            if (load_i) begin
                instr_o    <= instr_i;
                pc_o       <= pc_i;
                pc_plus4_o <= pc_i + ADDR_W'(4);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM: issues one memory request per instruction, buffers the word
// across decode stalls, squashes in-flight requests on flush.
module instr_fetch_unit
    import cpu_if_pkg::*;
#(
    parameter int unsigned           ADDR_W    = ADDR_W_DEF,
    parameter int unsigned           INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0]    NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               pc_write_o,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               ifid_valid_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic [ADDR_W-1:0]  ifid_pc_o,
    output logic [ADDR_W-1:0]  ifid_pc_plus4_o
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] buf_q;
    logic [ADDR_W-1:0]  fetch_pc_q;
    logic               complete;
    logic               cap_fetch;
    logic               cap_buf;
    logic [INSTR_W-1:0] ld_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ISSUE;
            buf_q      <= '0;
            fetch_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (cap_fetch) fetch_pc_q <= pc_i;
            if (cap_buf)   buf_q      <= imem_data_i;
        end
    end

    // Next state; flush outranks stall and ack in every state.
    always_comb begin
        state_d   = state_q;
        complete  = 1'b0;
        cap_fetch = 1'b0;
        cap_buf   = 1'b0;
        ld_data   = imem_data_i;
        case (state_q)
            ST_ISSUE: begin
                if (!flush_i) begin
                    cap_fetch = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = imem_ack_i ? ST_ISSUE : ST_DROP;
                end else if (imem_ack_i) begin
                    if (stall_i) begin
                        cap_buf = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        complete = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    state_d = ST_ISSUE;
                end else if (!stall_i) begin
                    complete = 1'b1;
                    ld_data  = buf_q;
                    state_d  = ST_ISSUE;
                end
            end
            ST_DROP: begin
                if (imem_ack_i && !flush_i) state_d = ST_ISSUE;
                else if (imem_ack_i)        state_d = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    assign imem_req_o  = (state_q == ST_ISSUE) && !flush_i && !rst_i;
    assign imem_addr_o = pc_i;
    assign pc_write_o  = (complete || flush_i) && !rst_i;

    if_id_reg #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .load_i     (complete),
        .instr_i    (ld_data),
        .pc_i       (fetch_pc_q),
        .valid_o    (ifid_valid_o),
        .instr_o    (ifid_instr_o),
        .pc_o       (ifid_pc_o),
        .pc_plus4_o (ifid_pc_plus4_o)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;
    import cpu_if_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        pc_write_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        flush_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc_plus4_o;

    int   errors = 0;
    int   checks = 0;
    logic rst_nxt = 1'b1;
    logic ack_chk_en = 1'b1;

    instr_fetch_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_i            (pc_i),
        .pc_write_o      (pc_write_o),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_pc_plus4_o (ifid_pc_plus4_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs after the falling edge, then settle.
    task automatic step(input logic [31:0] pc, input logic ack, input logic [31:0] data,
                        input logic stall, input logic flush);
        @(negedge clk_i);
        rst_i       = rst_nxt;
        pc_i        = pc;
        imem_ack_i  = ack;
        imem_data_i = data;
        stall_i     = stall;
        flush_i     = flush;
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] p4);
        chk({tag, ".valid"}, 32'(ifid_valid_o), 32'(v));
        chk({tag, ".instr"}, ifid_instr_o, instr);
        chk({tag, ".pc"}, ifid_pc_o, pc);
        chk({tag, ".pc4"}, ifid_pc_plus4_o, p4);
    endtask

    // Memory may only ack while a request is outstanding.
    always @(posedge clk_i) begin
        if (!rst_i && ack_chk_en && imem_ack_i) begin
            ack_in_state: assert (dut.state_q == ST_WAIT || dut.state_q == ST_DROP)
                else chk("ack_in_state", 32'(dut.state_q), 32'(ST_WAIT));
        end
    end

    initial begin
        rst_i = 1'b1; pc_i = '0; imem_ack_i = 1'b0; imem_data_i = '0;
        stall_i = 1'b0; flush_i = 1'b0;

        // Reset: flush must not raise pc_write while reset is held
        step(32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst.req", 32'(imem_req_o), 32'd0);
        chk("rst.pcw", 32'(pc_write_o), 32'd0);
        chk("rst.state", 32'(dut.state_q), 32'(ST_ISSUE));
        chk_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h0);

        // Best-case fetch, L=1
        rst_nxt = 1'b0;
        step(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("f1.req", 32'(imem_req_o), 32'd1);
        chk("f1.addr", imem_addr_o, 32'h100);
        chk("f1.pcw0", 32'(pc_write_o), 32'd0);
        step(32'h100, 1'b1, 32'h2008_0005, 1'b0, 1'b0);
        chk("f1.pcw1", 32'(pc_write_o), 32'd1);
        chk("f1.req_wait", 32'(imem_req_o), 32'd0);
        step(32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_ifid("f1", 1'b1, 32'h2008_0005, 32'h100, 32'h104);
        chk("f2.req", 32'(imem_req_o), 32'd1);
        chk("f2.addr", imem_addr_o, 32'h104);

        // Stall from the ack cycle for 3 cycles
        step(32'h104, 1'b1, 32'hAAAA_0001, 1'b1, 1'b0);
        chk("st.pcw_ack", 32'(pc_write_o), 32'd0);
        chk("st.bubble", 32'(ifid_valid_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(32'h104, 1'b0, 32'h0, 1'b1, 1'b0);
            chk("st.state", 32'(dut.state_q), 32'(ST_HOLD));
            chk("st.req", 32'(imem_req_o), 32'd0);
            chk("st.pcw", 32'(pc_write_o), 32'd0);
        end
        step(32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("st.rel_pcw", 32'(pc_write_o), 32'd1);
        chk("st.rel_req", 32'(imem_req_o), 32'd0);
        step(32'h108, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_ifid("st", 1'b1, 32'hAAAA_0001, 32'h104, 32'h108);
        chk("st.next_addr", imem_addr_o, 32'h108);
        step(32'h108, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("st.once", 32'(ifid_valid_o), 32'd0);
        chk("st.pcw_after", 32'(pc_write_o), 32'd0);
        chk("st.wait", 32'(dut.state_q), 32'(ST_WAIT));

        // Flush in WAIT, late ack 3 cycles later
        step(32'h200, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("fl.pcw", 32'(pc_write_o), 32'd1);
        chk("fl.req", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
            chk("fl.drop", 32'(dut.state_q), 32'(ST_DROP));
            chk("fl.drop_req", 32'(imem_req_o), 32'd0);
            chk("fl.drop_pcw", 32'(pc_write_o), 32'd0);
            chk("fl.valid", 32'(ifid_valid_o), 32'd0);
        end
        step(32'h200, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("fl.late_pcw", 32'(pc_write_o), 32'd0);
        step(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fl.discard", 32'(ifid_valid_o), 32'd0);
        chk("fl.instr_kept", ifid_instr_o, 32'hAAAA_0001);
        chk("fl.req_new", 32'(imem_req_o), 32'd1);
        chk("fl.addr_new", imem_addr_o, 32'h200);

        // Flush + stall + ack together in WAIT, redirect to the top of memory
        step(32'hFFFF_FFFC, 1'b1, 32'h1111_1111, 1'b1, 1'b1);
        chk("fsa.pcw", 32'(pc_write_o), 32'd1);
        step(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fsa.state", 32'(dut.state_q), 32'(ST_ISSUE));
        chk("fsa.valid", 32'(ifid_valid_o), 32'd0);
        chk("fsa.instr", ifid_instr_o, 32'hAAAA_0001);
        chk("fsa.addr", imem_addr_o, 32'hFFFF_FFFC);

        // PC+4 wraps to zero
        step(32'hFFFF_FFFC, 1'b1, 32'h0000_0013, 1'b0, 1'b0);
        chk("wrap.pcw", 32'(pc_write_o), 32'd1);
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_ifid("wrap", 1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0);
        chk("wrap.req", 32'(imem_req_o), 32'd1);

        // Asynchronous reset in the middle of a WAIT cycle
        step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("ar.pre", 32'(dut.state_q), 32'(ST_WAIT));
        #2 rst_i = 1'b1;
        #1;
        chk_ifid("ar", 1'b0, 32'h0, 32'h0, 32'h0);
        chk("ar.state", 32'(dut.state_q), 32'(ST_ISSUE));
        chk("ar.req", 32'(imem_req_o), 32'd0);
        chk("ar.pcw", 32'(pc_write_o), 32'd0);

        // Stale ack right after deassert is ignored
        ack_chk_en = 1'b0;
        step(32'h400, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0);
        chk("ar.stale_pcw", 32'(pc_write_o), 32'd0);
        chk("ar.stale_req", 32'(imem_req_o), 32'd1);
        step(32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
        ack_chk_en = 1'b1;
        chk("ar.no_load", 32'(ifid_valid_o), 32'd0);
        chk("ar.instr", ifid_instr_o, 32'h0);
        chk("ar.wait", 32'(dut.state_q), 32'(ST_WAIT));
        step(32'h400, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
        chk("ar.pcw_real", 32'(pc_write_o), 32'd1);
        step(32'h404, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_ifid("ar.real", 1'b1, 32'h0000_0055, 32'h400, 32'h404);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
